// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, memory
// depth default and the byte order used to pack the boot stream into words.
package cpu_pkg;

  localparam int IMEM_ADDR_W = 5;
  localparam bit BIG_ENDIAN  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  // Shift one stream byte into a partially assembled instruction word.
  function automatic logic [31:0] pack_byte(input logic [31:0] word,
                                            input logic [7:0]  b);
    return BIG_ENDIAN ? {word[23:0], b} : {b, word[31:8]};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles stream bytes into 32-bit words and keeps the running XOR
// checksum of every byte loaded since the last clear.
module byte_packer
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load,
  input  logic        clear,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        full_o,
  output logic [7:0]  chk_o
);

  logic [1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      word_o <= '0;
      cnt    <= '0;
      chk_o  <= '0;
    end else if (clear) begin
      word_o <= '0;
      cnt    <= '0;
      chk_o  <= '0;
    end else if (load) begin
      word_o <= pack_byte(word_o, byte_i);
      cnt    <= cnt + 2'd1;
      chk_o  <= chk_o ^ byte_i;
    end
  end

  // The next loaded byte completes a word; the counter wraps to 0 on it.
  assign full_o = (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes packed words into
// instruction memory from address 0 and releases the CPU once the checksum matches.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              byte_ready_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [31:0]       wdata_o,
  output logic              cpu_run_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int IDX_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  loader_state_t    state;
  logic [IDX_W-1:0] word_idx;
  logic [IDX_W-1:0] n_words;
  logic             accept;
  logic             hdr_bad;
  logic             pk_full;
  logic [31:0]      pk_word;
  logic [7:0]       pk_chk;

  assign accept  = byte_valid_i && byte_ready_o;
  assign hdr_bad = (byte_i == 8'd0) || (int'(byte_i) > DEPTH);

  byte_packer u_packer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load   (accept && (state == ST_LOAD)),
    .clear  (accept && (state == ST_HDR)),
    .byte_i (byte_i),
    .word_o (pk_word),
    .full_o (pk_full),
    .chk_o  (pk_chk)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      word_idx <= '0;
      n_words  <= '0;
      waddr_o  <= '0;
      wdata_o  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (start_i) state <= ST_HDR;
        ST_HDR: begin
          if (byte_valid_i) begin
            if (hdr_bad) begin
              state <= ST_ERR;
            end else begin
              n_words  <= IDX_W'(byte_i);
              word_idx <= '0;
              state    <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          // Capture the completed word now so the write address/data hold
          // steady through WRITE and afterwards.
          if (byte_valid_i && pk_full) begin
            waddr_o <= word_idx[ADDR_W-1:0];
            wdata_o <= pack_byte(pk_word, byte_i);
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          word_idx <= word_idx + IDX_W'(1);
          state    <= (word_idx + IDX_W'(1) == n_words) ? ST_CHK : ST_LOAD;
        end
        ST_CHK: if (byte_valid_i) state <= (byte_i == pk_chk) ? ST_DONE : ST_ERR;
        ST_DONE, ST_ERR: if (start_i) state <= ST_HDR;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Control outputs are pure decodes of the state register.
  assign byte_ready_o = state inside {ST_HDR, ST_LOAD, ST_CHK};
  assign busy_o       = state inside {ST_HDR, ST_LOAD, ST_WRITE, ST_CHK};
  assign we_o         = (state == ST_WRITE);
  assign done_o       = (state == ST_DONE);
  assign cpu_run_o    = (state == ST_DONE);
  assign err_o        = (state == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized checks of the boot loader against a stream-level model:
// expected writes and outcome are derived from the byte stream alone.
module tb_imem_loader;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              start_i = 1'b0;
  logic              byte_valid_i = 1'b0;
  logic [7:0]        byte_i = 8'h00;
  logic              byte_ready_o;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [31:0]       wdata_o;
  logic              cpu_run_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  int vectors = 0;
  int miscompares = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .byte_ready_o (byte_ready_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .cpu_run_o    (cpu_run_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Log every write strobe, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (we_o) begin
      wr_addr.push_back(waddr_o);
      wr_data.push_back(wdata_o);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Present one byte at a negedge and hold it until the following edge takes it.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int k;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    if (gap > 0) begin
      byte_valid_i = 1'b0;
      repeat (gap) @(negedge clk_i);
    end
    byte_valid_i = 1'b1;
    byte_i = b;
    k = 0;
    while (!byte_ready_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    if (k == 20) chk("ready_wait", {63'd0, byte_ready_o}, 64'd1);
    @(negedge clk_i);
  endtask

  task automatic make_stream(input int n, input bit corrupt, output logic [7:0] s[$]);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    s.delete();
    s.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      s.push_back(b);
    end
    s.push_back(corrupt ? (x ^ 8'h5a) : x);
  endtask

  // Start a load, feed the stream, then check outcome and write log against the model.
  task automatic run_load(input logic [7:0] s[$], input int max_gap, input int start_at,
                          input string tag);
    int         n;
    bit         hdr_ok;
    bit         pass;
    int         nsend;
    int         nexp;
    logic [7:0] x;
    logic [31:0] w;
    n = int'(s[0]);
    hdr_ok = (n != 0) && (n <= DEPTH);
    nsend = hdr_ok ? 4 * n + 2 : 1;
    nexp  = hdr_ok ? n : 0;
    x = 8'h00;
    for (int i = 1; i <= 4 * nexp; i++) x = x ^ s[i];
    pass = hdr_ok && (s[4 * n + 1] == x);

    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    chk({tag, "_ready_after_start"}, {63'd0, byte_ready_o}, 64'd1);
    chk({tag, "_run_low_after_start"}, {63'd0, cpu_run_o}, 64'd0);
    for (int i = 0; i < nsend; i++) begin
      if (i == start_at) start_i = 1'b1;
      send_byte(s[i], max_gap);
      start_i = 1'b0;
    end
    byte_valid_i = 1'b0;

    chk({tag, "_done"}, {63'd0, done_o}, {63'd0, pass});
    chk({tag, "_err"}, {63'd0, err_o}, {63'd0, !pass});
    chk({tag, "_cpu_run"}, {63'd0, cpu_run_o}, {63'd0, pass});
    chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    chk({tag, "_nwrites"}, 64'(wr_addr.size()), 64'(nexp));
    for (int i = 0; i < wr_addr.size() && i < nexp; i++) begin
      w = (32'(s[4*i+1]) << 24) | (32'(s[4*i+2]) << 16) | (32'(s[4*i+3]) << 8) | 32'(s[4*i+4]);
      chk({tag, "_waddr"}, 64'(wr_addr[i]), 64'(i));
      chk({tag, "_wdata"}, 64'(wr_data[i]), 64'(w));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, {63'd0, byte_ready_o}, 64'd0);
    chk({tag, "_we"}, {63'd0, we_o}, 64'd0);
    chk({tag, "_waddr"}, 64'(waddr_o), 64'd0);
    chk({tag, "_wdata"}, 64'(wdata_o), 64'd0);
    chk({tag, "_cpu_run"}, {63'd0, cpu_run_o}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    chk({tag, "_done"}, {63'd0, done_o}, 64'd0);
    chk({tag, "_err"}, {63'd0, err_o}, 64'd0);
  endtask

  initial begin
    logic [7:0] nom[$];
    logic [7:0] bad[$];
    logic [7:0] s[$];
    logic [7:0] h0[$];
    logic [7:0] h33[$];

    nom = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h03, 8'h05};
    bad = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h03, 8'h06};
    h0  = '{8'h00};
    h33 = '{8'h21};

    repeat (3) @(negedge clk_i);
    check_idle_outputs("reset");
    rst_i = 1'b1;
    @(negedge clk_i);
    check_idle_outputs("idle");

    run_load(nom, 0, -1, "nominal");
    run_load(bad, 0, 3, "bad_chk");
    run_load(h0, 0, -1, "hdr_zero");
    run_load(h33, 0, -1, "hdr_33");

    make_stream(DEPTH, 1'b0, s);
    run_load(s, 3, -1, "full_depth");
    if (wr_addr.size() > 0) chk("full_last_addr", 64'(wr_addr[wr_addr.size()-1]), 64'(DEPTH - 1));

    make_stream(7, 1'b0, s);
    run_load(s, 0, -1, "held_valid");

    for (int r = 0; r < 4; r++) begin
      make_stream(int'($urandom_range(DEPTH, 1)), ($urandom_range(3, 0) == 0), s);
      run_load(s, int'($urandom_range(2, 0)), -1, "random");
    end

    // Reset in the middle of the second word.
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(nom[i], 0);
    rst_i = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    repeat (4) @(negedge clk_i);
    chk("mid_reset_nwrites", 64'(wr_addr.size()), 64'd1);
    byte_valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    run_load(nom, 1, -1, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
